mole_game_core: RTL and testbench

MOLE_GAME_CORE -- requirements
Module: mole_game_core

---
 rtl/mole_game_core_pkg.sv | 27 ++
 rtl/mole_game_core_keypad_scan.sv | 95 +++++++++
 rtl/mole_game_core.sv | 140 ++++++++++++++
 tb/tb_mole_game_core.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mole_game_core_pkg.sv
// Shared types and constants for the whack-a-mole core: FSM states, LFSR
// definition and the score/miss limits.
package mole_game_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_SHOW,
    ST_HIT,
    ST_MISS
  } state_e;

  localparam logic [15:0] LFSR_SEED      = 16'hACE1;
  // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [7:0]  CNT_SAT        = 8'd255;
  localparam logic [7:0]  GAME_OVER_MISS = 8'd8;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mole_game_core_keypad_scan.sv
// 4x4 keypad column scanner with whole-scan debounce; emits a one-cycle
// key_valid pulse per accepted press.
module keypad_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_SCANS + 1);

  logic [DW-1:0] r_div;
  logic [1:0]    r_col_idx;
  logic          r_scan_hit;
  logic [3:0]    r_scan_code;
  logic [3:0]    r_last_code;
  logic [CW-1:0] r_deb_cnt;
  logic          r_locked;
  logic          r_valid;
  logic [3:0]    r_code;

  logic          w_slot_end, w_scan_end, w_row_hit, w_seen;
  logic [1:0]    w_row_idx;
  logic [3:0]    w_this_code, w_code;
  logic [CW-1:0] w_cnt_next;

  assign w_slot_end  = (r_div == DW'(SCAN_DIV - 1));
  assign w_scan_end  = w_slot_end && (r_col_idx == 2'd3);
  assign w_row_hit   = ~&row;
  assign w_this_code = {r_col_idx, w_row_idx};
  // the last slot of a scan still contributes to that scan's verdict
  assign w_seen      = r_scan_hit || w_row_hit;
  assign w_code      = r_scan_hit ? r_scan_code : w_this_code;

  always_comb begin
    w_row_idx = 2'd3;
    if      (!row[0]) w_row_idx = 2'd0;
    else if (!row[1]) w_row_idx = 2'd1;
    else if (!row[2]) w_row_idx = 2'd2;
  end

  always_comb begin
    w_cnt_next = CW'(1);
    if (w_code == r_last_code && r_deb_cnt != '0)
      w_cnt_next = (r_deb_cnt == CW'(DEB_SCANS)) ? r_deb_cnt : r_deb_cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div       <= '0;
      r_col_idx   <= 2'd0;
      r_scan_hit  <= 1'b0;
      r_scan_code <= 4'd0;
      r_last_code <= 4'd0;
      r_deb_cnt   <= '0;
      r_locked    <= 1'b0;
      r_valid     <= 1'b0;
      r_code      <= 4'd0;
    end else begin
      r_valid <= 1'b0;
      r_div   <= w_slot_end ? '0 : r_div + DW'(1);
      if (w_slot_end) begin
        r_col_idx <= r_col_idx + 2'd1;
        if (w_scan_end) begin
          r_scan_hit <= 1'b0;
          if (!w_seen) begin
            r_deb_cnt <= '0;
            r_locked  <= 1'b0;
          end else begin
            r_last_code <= w_code;
            r_deb_cnt   <= w_cnt_next;
            if (w_cnt_next == CW'(DEB_SCANS) && !r_locked) begin
              r_valid  <= 1'b1;
              r_code   <= w_code;
              r_locked <= 1'b1;
            end
          end
        end else if (w_row_hit && !r_scan_hit) begin
          r_scan_hit  <= 1'b1;
          r_scan_code <= w_this_code;
        end
      end
    end
  end

  assign col       = ~(4'b0001 << r_col_idx);
  assign key_code  = r_code;
  assign key_valid = r_valid;

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole game core: keypad front end, LFSR mole placement, game FSM,
// score/miss counters, progressive speed-up and buzzer feedback.
module mole_game_core
  import mole_game_core_pkg::*;
#(
  parameter int N_LED      = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_SCANS  = 3,
  parameter int MOLE_TICKS = 50000000,
  parameter int MIN_TICKS  = 12500000,
  parameter int FB_TICKS   = 10000000,
  parameter int TONE_DIV   = 25000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [N_LED-1:0] led,
  output logic             buzzer,
  output logic [7:0]       score,
  output logic [7:0]       miss,
  output logic             busy
);
  localparam int IW = $clog2(N_LED);

  logic [3:0]    w_key_code;
  logic          w_key_valid;
  state_e        r_state, w_next;
  logic [15:0]   r_lfsr;
  logic [IW-1:0] r_mole_idx, w_spawn_idx;
  logic [31:0]   r_timer, r_mole_ticks, r_tone, w_half;
  logic [7:0]    r_score, r_miss, w_score_inc;
  logic          r_buzz;
  logic          w_expire, w_key_hit, w_key_in_range;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS)) u_scan (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (w_key_code),
    .key_valid (w_key_valid)
  );

  assign w_expire       = (r_timer == 32'd0);
  assign w_key_in_range = ({1'b0, w_key_code} < 5'(N_LED));
  assign w_key_hit      = w_key_valid && (w_key_code == 4'(r_mole_idx));
  // never repeat the previous mole; power-of-two N_LED makes +1 wrap for free
  assign w_spawn_idx    = (r_lfsr[IW-1:0] == r_mole_idx) ? r_mole_idx + IW'(1) : r_lfsr[IW-1:0];
  assign w_score_inc    = sat_inc(r_score);
  assign w_half         = r_mole_ticks >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_key_valid) w_next = ST_SPAWN;
      ST_SPAWN: w_next = ST_SHOW;
      ST_SHOW: begin
        if (w_key_hit)                                 w_next = ST_HIT;
        else if (w_key_valid && w_key_in_range)        w_next = ST_MISS;
        else if (w_expire)                             w_next = ST_MISS;
      end
      ST_HIT:   if (w_expire) w_next = ST_SPAWN;
      ST_MISS:  if (w_expire) w_next = (r_miss == GAME_OVER_MISS) ? ST_IDLE : ST_SPAWN;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr       <= LFSR_SEED;
      r_mole_idx   <= '0;
      r_timer      <= 32'd0;
      r_mole_ticks <= 32'(MOLE_TICKS);
      r_score      <= 8'd0;
      r_miss       <= 8'd0;
      r_buzz       <= 1'b0;
      r_tone       <= 32'd0;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
      if (r_timer != 32'd0) r_timer <= r_timer - 32'd1;
      case (r_state)
        ST_IDLE: if (w_next == ST_SPAWN) begin
          r_score      <= 8'd0;
          r_miss       <= 8'd0;
          r_mole_ticks <= 32'(MOLE_TICKS);
        end
        ST_SPAWN: begin
          r_mole_idx <= w_spawn_idx;
          r_timer    <= r_mole_ticks - 32'd1;
        end
        ST_SHOW: begin
          if (w_next == ST_HIT) begin
            r_score <= w_score_inc;
            if (w_score_inc[2:0] == 3'd0)
              r_mole_ticks <= (w_half < 32'(MIN_TICKS)) ? 32'(MIN_TICKS) : w_half;
            r_timer <= 32'(FB_TICKS - 1);
            r_buzz  <= 1'b0;
            r_tone  <= 32'd0;
          end else if (w_next == ST_MISS) begin
            r_miss  <= sat_inc(r_miss);
            r_timer <= 32'(FB_TICKS - 1);
          end
        end
        ST_HIT: begin
          if (r_tone == 32'(TONE_DIV - 1)) begin
            r_tone <= 32'd0;
            r_buzz <= ~r_buzz;
          end else begin
            r_tone <= r_tone + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    led    = '0;
    buzzer = 1'b0;
    case (r_state)
      ST_SHOW: led[r_mole_idx] = 1'b1;
      ST_HIT: begin
        led    = '1;
        buzzer = r_buzz;
      end
      default: ;
    endcase
  end

  assign score = r_score;
  assign miss  = r_miss;
  assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mole_game_core.sv
// Directed bench for mole_game_core with fast timing parameters; the keypad
// is modelled by decoding col against the key currently held.
module tb_mole_game_core;
  import mole_game_core_pkg::*;

  localparam int N_LED = 8, SCAN_DIV = 4, DEB_SCANS = 2, MOLE_TICKS = 200;
  localparam int MIN_TICKS = 50, FB_TICKS = 20, TONE_DIV = 2;

  logic       clk = 1'b0, rst = 1'b1;
  logic [3:0] row, col;
  logic [7:0] led, score, miss;
  logic       buzzer, busy;
  logic       key_down = 1'b0;
  logic [3:0] tb_key = 4'd0;
  int n_checks = 0, n_fail = 0, prev_idx = 0;

  mole_game_core #(
    .N_LED(N_LED), .SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS), .MOLE_TICKS(MOLE_TICKS),
    .MIN_TICKS(MIN_TICKS), .FB_TICKS(FB_TICKS), .TONE_DIV(TONE_DIV)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .led(led),
    .buzzer(buzzer), .score(score), .miss(miss), .busy(busy)
  );

  always #5 clk = ~clk;

  assign row = (key_down && col == ~(4'b0001 << tb_key[3:2])) ? ~(4'b0001 << tb_key[1:0]) : 4'hF;

  function automatic bit is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
  endfunction

  function automatic int idx_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Press the key under the lit mole and return once the HIT state shows.
  task automatic hit_mole(output bit ok, output int idx);
    ok = 1'b0;
    idx = -1;
    for (int t = 0; t < 300 && !is_onehot(led); t++) @(negedge clk);
    if (!is_onehot(led)) return;
    idx = idx_of(led);
    tb_key = 4'(idx);
    key_down = 1'b1;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (led == 8'hFF) begin ok = 1'b1; break; end
    end
    key_down = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (col !== 4'hE) begin n_fail++; $display("FAIL reset_col: got %h want e", col); end
    n_checks++; if ({led, buzzer, busy} !== 10'd0) begin n_fail++; $display("FAIL reset_out: led=%h buz=%b busy=%b want 0", led, buzzer, busy); end
    n_checks++; if ({score, miss} !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: score=%0d miss=%0d want 0", score, miss); end
    n_checks++; if (dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.r_state); end
    rst = 1'b0;
  endtask

  task automatic test_idle_scan;
    logic [3:0] one, exp_col;
    one = 4'b0001;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      exp_col = ~(one << ((n / 4) % 4));
      n_checks++; if (col !== exp_col) begin n_fail++; $display("FAIL idle_col[%0d]: got %h want %h", n, col, exp_col); end
      n_checks++; if ({led, score, busy} !== 17'd0) begin n_fail++; $display("FAIL idle_out[%0d]: led=%h score=%0d busy=%b want 0", n, led, score, busy); end
    end
  endtask

  task automatic test_start;
    int pulses;
    bit got;
    pulses = 0;
    got = 1'b0;
    tb_key = 4'd0;
    key_down = 1'b1;
    for (int t = 0; t < 80 && !got; t++) begin
      @(negedge clk);
      if (dut.w_key_valid) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL start_accept: no key pulse within 80 cycles, want one");
    end else begin
      pulses = 1;
      @(negedge clk);
      n_checks++; if (dut.r_state !== ST_SPAWN) begin n_fail++; $display("FAIL start_spawn: state %0d want SPAWN", dut.r_state); end
      @(negedge clk);
      n_checks++; if (dut.r_state !== ST_SHOW || !is_onehot(led)) begin n_fail++; $display("FAIL start_show: state %0d led %h want SHOW one-hot", dut.r_state, led); end
      n_checks++; if (idx_of(led) == prev_idx) begin n_fail++; $display("FAIL start_repeat: mole %0d equals previous %0d", idx_of(led), prev_idx); end
      prev_idx = idx_of(led);
      repeat (40) begin
        @(negedge clk);
        if (dut.w_key_valid) pulses++;
      end
      n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL start_pulses: got %0d want 1", pulses); end
    end
    key_down = 1'b0;
    repeat (32) @(negedge clk);
  endtask

  task automatic test_hit;
    bit ok;
    int idx;
    hit_mole(ok, idx);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL hit_enter: HIT not reached, led %h want ff", led); return; end
    n_checks++; if (score !== 8'd1) begin n_fail++; $display("FAIL hit_score: got %0d want 1", score); end
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      n_checks++;
      if ({led, buzzer} !== {8'hFF, 1'((k / 2) % 2)}) begin
        n_fail++; $display("FAIL hit_fb[%0d]: led=%h buz=%b want ff %0d", k, led, buzzer, (k / 2) % 2);
      end
    end
    @(negedge clk);
    n_checks++; if (led !== 8'h00 || dut.r_state !== ST_SPAWN) begin n_fail++; $display("FAIL hit_exit: led %h state %0d want 0 SPAWN", led, dut.r_state); end
    @(negedge clk);
    n_checks++; if (!is_onehot(led) || idx_of(led) == prev_idx) begin n_fail++; $display("FAIL hit_new_mole: led %h prev %0d want new one-hot", led, prev_idx); end
    prev_idx = idx_of(led);
  endtask

  task automatic test_miss;
    int n;
    for (int i = 0; i < 8; i++) begin
      for (int t = 0; t < 300 && !is_onehot(led); t++) @(negedge clk);
      n_checks++;
      if (!is_onehot(led)) begin n_fail++; $display("FAIL miss_wait[%0d]: no mole, led %h", i, led); return; end
      if (i > 0) begin
        n_checks++; if (idx_of(led) == prev_idx) begin n_fail++; $display("FAIL miss_repeat[%0d]: mole %0d equals previous", i, prev_idx); end
      end
      prev_idx = idx_of(led);
      n = 0;
      while (is_onehot(led) && n < 300) begin n++; @(negedge clk); end
      n_checks++; if (n != MOLE_TICKS) begin n_fail++; $display("FAIL miss_show_len[%0d]: got %0d want %0d", i, n, MOLE_TICKS); end
      n_checks++; if (miss !== 8'(i + 1)) begin n_fail++; $display("FAIL miss_count[%0d]: got %0d want %0d", i, miss, i + 1); end
      for (int k = 0; k < 20; k++) begin
        if (k > 0) @(negedge clk);
        n_checks++; if ({led, busy} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL miss_fb[%0d.%0d]: led=%h busy=%b want 0 1", i, k, led, busy); end
      end
      @(negedge clk);
      n_checks++; if (busy !== (i < 7)) begin n_fail++; $display("FAIL miss_exit[%0d]: busy %b want %0d", i, busy, i < 7); end
    end
    n_checks++; if (score !== 8'd1) begin n_fail++; $display("FAIL miss_score_kept: got %0d want 1", score); end
  endtask

  task automatic test_ignore;
    int idx, pulses;
    logic [7:0] exp_led;
    tb_key = 4'd15;
    key_down = 1'b1;
    for (int t = 0; t < 80 && !busy; t++) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_start: busy %b want 1 after key 15", busy); return; end
    n_checks++; if ({score, miss} !== 16'd0) begin n_fail++; $display("FAIL ign_clear: score=%0d miss=%0d want 0", score, miss); end
    n_checks++; if (dut.r_mole_ticks !== 32'(MOLE_TICKS)) begin n_fail++; $display("FAIL ign_ticks: got %0d want %0d", dut.r_mole_ticks, MOLE_TICKS); end
    key_down = 1'b0;
    @(negedge clk);
    n_checks++; if (!is_onehot(led) || idx_of(led) == prev_idx) begin n_fail++; $display("FAIL ign_mole: led %h prev %0d", led, prev_idx); return; end
    idx = idx_of(led);
    prev_idx = idx;
    exp_led = 8'h01 << idx;
    repeat (32) @(negedge clk);
    tb_key = 4'd9;
    key_down = 1'b1;
    pulses = 0;
    repeat (56) begin
      @(negedge clk);
      if (dut.w_key_valid) pulses++;
    end
    key_down = 1'b0;
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL ign_accept: key 9 pulses %0d want 1", pulses); end
    n_checks++; if (led !== exp_led || miss !== 8'd0) begin n_fail++; $display("FAIL ign_out_of_range: led %h miss %0d want %h 0", led, miss, exp_led); end
    repeat (32) @(negedge clk);
    tb_key = 4'((idx + 1) % 8);
    key_down = 1'b1;
    for (int t = 0; t < 60 && led != 8'h00; t++) @(negedge clk);
    key_down = 1'b0;
    n_checks++; if (led !== 8'h00 || miss !== 8'd1 || score !== 8'd0) begin n_fail++; $display("FAIL ign_wrong_key: led %h miss %0d score %0d want 0 1 0", led, miss, score); end
  endtask

  task automatic test_speedup;
    bit ok;
    int idx;
    for (int h = 1; h <= 24; h++) begin
      hit_mole(ok, idx);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL speed_hit[%0d]: HIT not reached", h); return; end
      n_checks++; if (idx == prev_idx) begin n_fail++; $display("FAIL speed_repeat[%0d]: mole %0d equals previous", h, idx); end
      prev_idx = idx;
      if (h % 8 == 0) begin
        n_checks++; if (score !== 8'(h)) begin n_fail++; $display("FAIL speed_score[%0d]: got %0d want %0d", h, score, h); end
        n_checks++;
        if (dut.r_mole_ticks !== ((h == 8) ? 32'd100 : 32'd50)) begin
          n_fail++; $display("FAIL speed_ticks[%0d]: got %0d want %0d", h, dut.r_mole_ticks, (h == 8) ? 100 : 50);
        end
      end
    end
  endtask

  task automatic test_reset_mid_hit;
    repeat (2) @(negedge clk);
    n_checks++; if ({led, buzzer, score} !== {8'hFF, 1'b1, 8'd24}) begin n_fail++; $display("FAIL rst_pre: led %h buz %b score %0d want ff 1 24", led, buzzer, score); end
    rst = 1'b1;
    #1;
    n_checks++; if ({led, buzzer, busy} !== 10'd0) begin n_fail++; $display("FAIL rst_mid_out: led=%h buz=%b busy=%b want 0", led, buzzer, busy); end
    n_checks++; if ({score, miss} !== 16'd0) begin n_fail++; $display("FAIL rst_mid_cnt: score=%0d miss=%0d want 0", score, miss); end
    n_checks++; if (col !== 4'hE) begin n_fail++; $display("FAIL rst_mid_col: got %h want e", col); end
    n_checks++; if (dut.r_mole_ticks !== 32'(MOLE_TICKS)) begin n_fail++; $display("FAIL rst_mid_ticks: got %0d want %0d", dut.r_mole_ticks, MOLE_TICKS); end
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    n_checks++; if ({score, busy} !== 9'd0) begin n_fail++; $display("FAIL rst_after: score=%0d busy=%b want 0", score, busy); end
  endtask

  initial begin
    test_reset;
    test_idle_scan;
    test_start;
    test_hit;
    test_miss;
    test_ignore;
    test_speedup;
    test_reset_mid_hit;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
